// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier. One shared CSA_32bits adder does the add or subtract step for each of the 32 iterations.
// Optional macro BOOTH_MULT_ZERO_BYPASS_EN: a zero operand seen in IDLE completes on the next cycle.

module CSA_32bits (
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);
  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  // The upper half is computed for both carry values, and the low half's carry then selects one.
  assign lo       = {1'b0, in_a[15:0]} + {1'b0, in_b[15:0]} + {16'd0, cin};
  assign hi0      = {1'b0, in_a[31:16]} + {1'b0, in_b[31:16]};
  assign hi1      = {1'b0, in_a[31:16]} + {1'b0, in_b[31:16]} + 17'd1;
  assign sum      = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
  assign cout     = lo[16] ? hi1[16] : hi0[16];
  assign overflow = (in_a[31] == in_b[31]) && (sum[31] != in_a[31]);
endmodule

module booth_mult_seq #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] m_p0;
  logic signed [WIDTH-1:0] u_p0;
  logic signed [WIDTH-1:0] l_p0;
  logic                    q1_p0;
  logic [CNT_WIDTH-1:0]    cnt_p0;

  logic                    do_op;
  logic                    sub_op;
  logic [WIDTH-1:0]        add_b;
  logic [WIDTH-1:0]        sum;
  logic                    add_ovf;
  logic                    unused_cout;
  logic [WIDTH-1:0]        upd;
  logic                    zero_op;
  logic                    bypass;

  // The true sign of the 33-bit add/sub result is sum MSB corrected by overflow, which keeps M = -2^31 exact.
  function automatic logic shift_in(input logic op, input logic [WIDTH-1:0] s,
                                    input logic v, input logic u_msb);
    return op ? (s[WIDTH-1] ^ v) : u_msb;
  endfunction

  function automatic logic out_of_range(input logic [WIDTH-1:0] hi, input logic lo_msb);
    return hi != {WIDTH{lo_msb}};
  endfunction

`ifdef BOOTH_MULT_ZERO_BYPASS_EN
  assign zero_op = (data_operandA == '0) || (data_operandB == '0);
`else
  assign zero_op = 1'b0;
`endif
  assign bypass = (state == IDLE) && zero_op;

  // Booth decode of {L[0], q_1}: 01 adds M, 10 subtracts M, 00/11 pass U through.
  assign do_op  = l_p0[0] ^ q1_p0;
  assign sub_op = l_p0[0] & ~q1_p0;
  assign add_b  = sub_op ? ~m_p0 : m_p0;

  CSA_32bits u_adder (
    .in_a     (u_p0),
    .in_b     (add_b),
    .cin      (sub_op),
    .sum      (sum),
    .cout     (unused_cout),
    .overflow (add_ovf)
  );

  assign upd = do_op ? sum : u_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ctrl_MULT) begin
      state_nxt = bypass ? DONE : RUN;
    end else begin
      case (state)
        RUN:     if (cnt_p0 == CNT_WIDTH'(WIDTH - 1)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Iteration stage: load on start, shift P each RUN cycle, publish results from DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_p0           <= '0;
      u_p0           <= '0;
      l_p0           <= '0;
      q1_p0          <= 1'b0;
      cnt_p0         <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      m_p0           <= data_operandA;
      u_p0           <= '0;
      l_p0           <= bypass ? '0 : data_operandB;
      q1_p0          <= 1'b0;
      cnt_p0         <= '0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        RUN: begin
          u_p0   <= {shift_in(do_op, sum, add_ovf, u_p0[WIDTH-1]), upd[WIDTH-1:1]};
          l_p0   <= {upd[0], l_p0[WIDTH-1:1]};
          q1_p0  <= l_p0[0];
          cnt_p0 <= cnt_p0 + CNT_WIDTH'(1);
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          data_result    <= l_p0;
          data_exception <= out_of_range(u_p0, l_p0[WIDTH-1]);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Multi-cycle signed 32x32 multiplier using radix-2 Booth recoding.
- Sits directly downstream of the 32-bit carry-select adder (CSA_32bits) and instantiates exactly one copy of it, reused once per iteration for the add or subtract step.
- Produces a 32-bit truncated product plus an overflow exception.
- Feeds the execute stage's multdiv result mux.

Parameters:
- WIDTH, 32, operand/result width; must equal the adder width (only 32 supported).
- CNT_WIDTH, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- ctrl_MULT  input  1  start pulse; samples operands on the same edge.
- data_operandA  input  32  multiplicand M, two's complement.
- data_operandB  input  32  multiplier Q, two's complement.
- data_result  output  32  low 32 bits of A*B.
- data_exception  output  1  product not representable in signed 32 bits.
- data_resultRDY  output  1  one-cycle pulse; result and exception valid.
- busy  output  1  high while iterating.

Behaviour:
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0, product register=0.
- Internal state: 65-bit register P = {U[31:0], L[31:0], q_1}, latched multiplicand M, counter.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on ctrl_MULT. The same edge loads M=A, U=0, L=B, q_1=0, counter=0, busy=1.
- RUN, each cycle, decode {L[0], q_1}:
  - 01: U + M via adder, cin=0.
  - 10: U + ~M via adder, cin=1.
  - 00/11: no operation; U passes through.
- RUN shift: P shifts arithmetically right one bit. The shift-in MSB is sum[31] XOR adder overflow when an add/sub occurred, else U[31]. This keeps M = -2^31 correct.
- RUN counter: increments every cycle. After the 32nd iteration, go to DONE.
- DONE lasts exactly one cycle:
  - data_resultRDY=1, busy=0.
  - data_result=L.
  - data_exception=1 iff U is not all copies of L[31].
  - Then return to IDLE.
- Latency: data_resultRDY is high in the cycle following the 33rd rising edge after the edge that sampled ctrl_MULT.
- data_result and data_exception hold their values until the next DONE or reset.
- data_resultRDY is 0 in all states except DONE.
- ctrl_MULT in RUN or DONE aborts the current operation and restarts with the new operands. No pulse is emitted for the aborted operation.
- Reset asserted mid-operation clears immediately, independent of clock. No pulse is emitted.
- Adder cout is unused. Adder overflow is used only for the shift-in bit.
- ctrl_MULT held high for several cycles: each cycle restarts. Only the last sample completes.

Optional Feature:
- Macro: BOOTH_MULT_ZERO_BYPASS_EN.
- Defined: in IDLE, if ctrl_MULT arrives with A==0 or B==0, skip RUN and go directly to DONE. data_resultRDY then pulses one cycle after the sampling edge, with result 0 and exception 0.
- Undefined: zero operands take the full 33-cycle path; result and exception are identical.

Test Plan:
- Reset mid-operation: after reset in RUN, all outputs are 0 and no data_resultRDY pulse follows. A subsequent 3 x -5 yields 0xFFFFFFF1, exception 0, data_resultRDY exactly 33 cycles after start.
- Large operands: 0x7FFFFFFF x 2 -> result 0xFFFFFFFE, exception 1. 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
- Most-negative multiplicand: 0x80000000 x 0xFFFFFFFF -> result 0x80000000, exception 1. 0x80000000 x 1 -> result 0x80000000, exception 0 (checks the shift-in fix).
- Abort: ctrl_MULT for 7x6 at cycle 0, then a new ctrl_MULT for -4x-4 at cycle 10 -> single pulse at cycle 43 with result 0x00000010. No pulse at cycle 33.
- Zero operand, 0 x 0x12345678 -> result 0, exception 0. Pulse one cycle after start with BOOTH_MULT_ZERO_BYPASS_EN, 33 cycles after start without it.
- Back-to-back: ctrl_MULT asserted in the DONE cycle of a prior op -> the prior pulse is suppressed and the new op completes 33 cycles later. busy stays high throughout.
